axis_broadcast: RTL and testbench

Parametrised AXI-Stream broadcaster that replicates one input stream onto `NOUT` output streams with full per-output `tready` backpressure. A per-output enable mask is sampled at packet boundaries. It is the flow-controlled, N-way successor to the sniffer's fixed two-way, no-backpressure stream tee. It sits between a packet source and several consumers, for example a capture FIFO, a filter and a statistics engine, that may stall independently.

---
 rtl/axis_broadcast.sv | 110 +++++++++++
 tb/tb_axis_broadcast.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_broadcast.sv
// axis_broadcast: replicates one AXI-Stream input onto NOUT outputs.
// Each output has its own tready backpressure. A per-output enable mask is
// sampled at start-of-packet and held for the whole packet.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   out_enable[NOUT]         output select, sampled at start-of-packet
//   axis_in_*                input stream (tdata/tkeep/tlast/tvalid/tready)
//   axis_out_*               NOUT output streams, output i at slice i
//   packet_count[32]         count of accepted input packets (wraps)
module axis_broadcast #(
    parameter int unsigned DW   = 512,
    parameter int unsigned NOUT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NOUT-1:0]        out_enable,
    input  logic [DW-1:0]          axis_in_tdata,
    input  logic [DW/8-1:0]        axis_in_tkeep,
    input  logic                   axis_in_tlast,
    input  logic                   axis_in_tvalid,
    output logic                   axis_in_tready,
    output logic [NOUT*DW-1:0]     axis_out_tdata,
    output logic [NOUT*DW/8-1:0]   axis_out_tkeep,
    output logic [NOUT-1:0]        axis_out_tlast,
    output logic [NOUT-1:0]        axis_out_tvalid,
    input  logic [NOUT-1:0]        axis_out_tready,
    output logic [31:0]            packet_count
);

    localparam int unsigned KW = DW / 8;
    localparam int unsigned CW = 32;

    // Holding register and per-output pending bits
    logic [DW-1:0]   data_q, data_d;
    logic [KW-1:0]   keep_q, keep_d;
    logic            last_q, last_d;
    logic [NOUT-1:0] pending_q, pending_d;
    logic [NOUT-1:0] pkt_mask_q, pkt_mask_d;
    logic            sop_q, sop_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NOUT-1:0] done_c;
    logic [NOUT-1:0] mask_c;
    logic            in_ready_c;
    logic            accept_c;

    // Next-state logic: drain served outputs, reload on an accepted beat
    always_comb begin
        done_c     = pending_q & axis_out_tready;
        // Ready once every pending output is served now or already drained;
        // this is the only tready-to-tready combinational path.
        in_ready_c = ~reset & ((pending_q & ~done_c) == '0);
        accept_c   = axis_in_tvalid & in_ready_c;
        mask_c     = sop_q ? out_enable : pkt_mask_q;

        pending_d  = pending_q & ~done_c;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        pkt_mask_d = pkt_mask_q;
        sop_d      = sop_q;
        cnt_d      = cnt_q;

        if (accept_c) begin
            // A null mask leaves pending at zero: the beat is dropped.
            pending_d = mask_c;
            data_d    = axis_in_tdata;
            keep_d    = axis_in_tkeep;
            last_d    = axis_in_tlast;
            sop_d     = axis_in_tlast;
            if (sop_q) begin
                pkt_mask_d = out_enable;
            end
            if (axis_in_tlast) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            pending_q  <= '0;
            pkt_mask_q <= '0;
            sop_q      <= 1'b1;
            cnt_q      <= '0;
        end else begin
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            pending_q  <= pending_d;
            pkt_mask_q <= pkt_mask_d;
            sop_q      <= sop_d;
            cnt_q      <= cnt_d;
        end
    end

    // Every output presents the same holding register
    assign axis_in_tready  = in_ready_c;
    assign axis_out_tdata  = {NOUT{data_q}};
    assign axis_out_tkeep  = {NOUT{keep_q}};
    assign axis_out_tlast  = {NOUT{last_q}};
    assign axis_out_tvalid = pending_q;
    assign packet_count    = cnt_q;

endmodule

// File: tb/tb_axis_broadcast.sv
// Bench for axis_broadcast with NOUT=3, DW=32: a table of per-cycle vectors
// with hand-derived ready/valid expectations, backed by a per-output
// scoreboard queue, plus hand-written reset and counter-wrap sequences.
module tb_axis_broadcast;

    localparam int unsigned DW   = 32;
    localparam int unsigned KW   = DW / 8;
    localparam int unsigned NOUT = 3;
    localparam int unsigned NVEC = 23;

    logic                 clk;
    logic                 reset;
    logic [NOUT-1:0]      out_enable;
    logic [DW-1:0]        axis_in_tdata;
    logic [KW-1:0]        axis_in_tkeep;
    logic                 axis_in_tlast;
    logic                 axis_in_tvalid;
    logic                 axis_in_tready;
    logic [NOUT*DW-1:0]   axis_out_tdata;
    logic [NOUT*KW-1:0]   axis_out_tkeep;
    logic [NOUT-1:0]      axis_out_tlast;
    logic [NOUT-1:0]      axis_out_tvalid;
    logic [NOUT-1:0]      axis_out_tready;
    logic [31:0]          packet_count;

    axis_broadcast #(.DW(DW), .NOUT(NOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .out_enable      (out_enable),
        .axis_in_tdata   (axis_in_tdata),
        .axis_in_tkeep   (axis_in_tkeep),
        .axis_in_tlast   (axis_in_tlast),
        .axis_in_tvalid  (axis_in_tvalid),
        .axis_in_tready  (axis_in_tready),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tkeep  (axis_out_tkeep),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .packet_count    (packet_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]   data;
        logic            last;
        logic            valid;
        logic [NOUT-1:0] en;
        logic [NOUT-1:0] rdy;
        logic            exp_in_rdy;
        logic [NOUT-1:0] exp_vld;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    vec_t  vecs [NVEC];
    beat_t exp_q [NOUT][$];

    int          errors = 0;
    int          checks = 0;
    logic        sop_m = 1'b1;
    logic [2:0]  pkt_m = '0;
    logic [31:0] cnt_m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs already driven at the falling edge; compare,
    // update the model for the coming rising edge, then return at the next
    // falling edge.
    task automatic cycle(input bit use_tab, input logic exp_in, input logic [NOUT-1:0] exp_vld);
        logic          rdy_m;
        logic [2:0]    m;
        beat_t         b;
        #1;
        if (use_tab) begin
            chk("tab_in_tready", 32'(axis_in_tready), 32'(exp_in));
            chk("tab_tvalid", 32'(axis_out_tvalid), 32'(exp_vld));
        end
        rdy_m = !reset;
        for (int i = 0; i < NOUT; i++)
            if (exp_q[i].size() != 0 && !axis_out_tready[i]) rdy_m = 1'b0;
        chk("in_tready", 32'(axis_in_tready), 32'(rdy_m));
        chk("packet_count", packet_count, cnt_m);
        for (int i = 0; i < NOUT; i++) begin
            chk($sformatf("tvalid%0d", i), 32'(axis_out_tvalid[i]), 32'(exp_q[i].size() != 0));
            if (exp_q[i].size() != 0) begin
                b = exp_q[i][0];
                chk($sformatf("tdata%0d", i), axis_out_tdata[i*DW +: DW], b.data);
                chk($sformatf("tkeep%0d", i), 32'(axis_out_tkeep[i*KW +: KW]), 32'(b.keep));
                chk($sformatf("tlast%0d", i), 32'(axis_out_tlast[i]), 32'(b.last));
                if (axis_out_tready[i]) void'(exp_q[i].pop_front());
            end
        end
        if (reset) begin
            for (int i = 0; i < NOUT; i++) exp_q[i].delete();
            sop_m = 1'b1;
            pkt_m = '0;
            cnt_m = '0;
        end else if (axis_in_tvalid && rdy_m) begin
            m = sop_m ? out_enable : pkt_m;
            if (sop_m) pkt_m = out_enable;
            b.data = axis_in_tdata;
            b.keep = axis_in_tkeep;
            b.last = axis_in_tlast;
            for (int i = 0; i < NOUT; i++)
                if (m[i]) exp_q[i].push_back(b);
            sop_m = axis_in_tlast;
            if (axis_in_tlast) cnt_m = cnt_m + 32'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic l, input logic v,
                         input logic [NOUT-1:0] en, input logic [NOUT-1:0] r);
        axis_in_tdata   = d;
        axis_in_tkeep   = KW'(~d);
        axis_in_tlast   = l;
        axis_in_tvalid  = v;
        out_enable      = en;
        axis_out_tready = r;
    endtask

    initial begin
        // data, last, valid, en, rdy, exp_in_rdy, exp_vld
        // streaming, all enabled
        vecs[0]  = '{32'd1,  1'b0, 1'b1, 3'b111, 3'b111, 1'b1, 3'b000};
        vecs[1]  = '{32'd2,  1'b0, 1'b1, 3'b111, 3'b111, 1'b1, 3'b111};
        vecs[2]  = '{32'd3,  1'b0, 1'b1, 3'b111, 3'b111, 1'b1, 3'b111};
        vecs[3]  = '{32'd4,  1'b1, 1'b1, 3'b111, 3'b111, 1'b1, 3'b111};
        vecs[4]  = '{32'd0,  1'b0, 1'b0, 3'b111, 3'b111, 1'b1, 3'b111};
        vecs[5]  = '{32'd0,  1'b0, 1'b0, 3'b111, 3'b111, 1'b1, 3'b000};
        // output 1 stalls three cycles
        vecs[6]  = '{32'd5,  1'b1, 1'b1, 3'b111, 3'b111, 1'b1, 3'b000};
        vecs[7]  = '{32'd6,  1'b1, 1'b1, 3'b111, 3'b101, 1'b0, 3'b111};
        vecs[8]  = '{32'd6,  1'b1, 1'b1, 3'b111, 3'b101, 1'b0, 3'b010};
        vecs[9]  = '{32'd6,  1'b1, 1'b1, 3'b111, 3'b101, 1'b0, 3'b010};
        vecs[10] = '{32'd6,  1'b1, 1'b1, 3'b111, 3'b111, 1'b1, 3'b010};
        vecs[11] = '{32'd0,  1'b0, 1'b0, 3'b111, 3'b111, 1'b1, 3'b111};
        vecs[12] = '{32'd0,  1'b0, 1'b0, 3'b111, 3'b111, 1'b1, 3'b000};
        // enable changes mid-packet, next packet follows the new enable
        vecs[13] = '{32'd10, 1'b0, 1'b1, 3'b011, 3'b111, 1'b1, 3'b000};
        vecs[14] = '{32'd11, 1'b0, 1'b1, 3'b100, 3'b111, 1'b1, 3'b011};
        vecs[15] = '{32'd12, 1'b0, 1'b1, 3'b100, 3'b111, 1'b1, 3'b011};
        vecs[16] = '{32'd13, 1'b1, 1'b1, 3'b100, 3'b111, 1'b1, 3'b011};
        vecs[17] = '{32'd14, 1'b1, 1'b1, 3'b100, 3'b111, 1'b1, 3'b011};
        vecs[18] = '{32'd0,  1'b0, 1'b0, 3'b100, 3'b111, 1'b1, 3'b100};
        vecs[19] = '{32'd0,  1'b0, 1'b0, 3'b100, 3'b111, 1'b1, 3'b000};
        // null mask
        vecs[20] = '{32'd20, 1'b0, 1'b1, 3'b000, 3'b111, 1'b1, 3'b000};
        vecs[21] = '{32'd21, 1'b1, 1'b1, 3'b000, 3'b111, 1'b1, 3'b000};
        vecs[22] = '{32'd0,  1'b0, 1'b0, 3'b000, 3'b111, 1'b1, 3'b000};

        reset = 1'b1;
        drive(32'd0, 1'b0, 1'b0, 3'b000, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle(1'b1, 1'b0, 3'b000);
        reset = 1'b0;

        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].data, vecs[v].last, vecs[v].valid, vecs[v].en, vecs[v].rdy);
            cycle(1'b1, vecs[v].exp_in_rdy, vecs[v].exp_vld);
        end
        chk("count_after_table", packet_count, 32'd6);

        // reset with a held, stalled beat
        drive(32'd30, 1'b0, 1'b1, 3'b111, 3'b000);
        cycle(1'b0, 1'b0, 3'b000);
        drive(32'd31, 1'b0, 1'b0, 3'b111, 3'b000);
        cycle(1'b1, 1'b0, 3'b111);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 3'b111);
        cycle(1'b1, 1'b0, 3'b000);
        chk("count_in_reset", packet_count, 32'd0);
        reset = 1'b0;
        drive(32'd31, 1'b1, 1'b1, 3'b001, 3'b111);
        cycle(1'b1, 1'b1, 3'b000);
        drive(32'd0, 1'b0, 1'b0, 3'b111, 3'b111);
        cycle(1'b1, 1'b1, 3'b001);
        cycle(1'b1, 1'b1, 3'b000);
        chk("count_after_reset", packet_count, 32'd1);

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        cnt_m = 32'hFFFF_FFFF;
        drive(32'd40, 1'b1, 1'b1, 3'b111, 3'b111);
        cycle(1'b1, 1'b1, 3'b000);
        drive(32'd0, 1'b0, 1'b0, 3'b111, 3'b111);
        cycle(1'b1, 1'b1, 3'b111);
        chk("count_wrap", packet_count, 32'd0);
        cycle(1'b1, 1'b1, 3'b000);

        for (int i = 0; i < NOUT; i++)
            chk($sformatf("drained%0d", i), 32'(exp_q[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
